fpu_issue_queue: RTL and testbench
==================================

Name: fpu_issue_queue

Overview:
Operand/command buffer directly upstream of the fpu. It accepts operation requests (operand A, operand B, 4-bit command) from the core side and queues them in a small circular FIFO. It then presents each queued request to the fpu input port using the rdy/ack handshake. This decouples core issue timing from fpu multi-cycle latency.

Parameters:
bitness, 32, operand width; one of 16/32/64/128/256.
depth, 4, FIFO entries; power of two, >= 2.

Ports:
clock  in  1  rising-edge clock.
reset  in  1  asynchronous, active-low reset.
req_rdy  in  1  core has a request on req_a/req_b/req_command.
req_ack  out  1  one-cycle pulse: request written into FIFO.
req_a  in  bitness  operand A.
req_b  in  bitness  operand B.
req_command  in  4  operation code.
fpu_input_rdy  out  1  head entry valid on fpu_data_a/b/command.
fpu_input_ack  in  1  fpu accepted the presented entry.
fpu_data_a  out  bitness  head operand A (registered).
fpu_data_b  out  bitness  head operand B (registered).
fpu_command  out  4  head command (registered).
count  out  $clog2(depth)+1  current occupancy, 0..depth.
cmd_err  out  1  sticky illegal-command flag (see Optional Feature).

Behaviour:
- Reset (reset==0, async): req_ack=0, fpu_input_rdy=0, fpu_data_a/b=0, fpu_command=0, count=0, cmd_err=0, read/write pointers=0, state=IDLE. All queued entries are discarded. Reset asserted mid-handshake aborts the transfer and does not complete it.
- Write side: at an edge where req_rdy==1, req_ack==0 and count<depth, store {req_a,req_b,req_command} at wr_ptr, increment wr_ptr (wraps at depth), and set req_ack=1 for exactly one cycle.
  - The req_ack==0 qualifier prevents a held request from being written twice.
  - Peak write rate is one request per 2 cycles.
- Full (count==depth): req_ack stays 0 and the request is held off with no loss. It is accepted on the first edge after a pop frees a slot.
- Read side FSM, states IDLE, PRESENT, GAP:
  - IDLE: if count>0 (post-write value visible), load head into fpu_data_*, set fpu_input_rdy=1, go to PRESENT. A request written at edge N to an empty queue gives fpu_input_rdy=1 after edge N+1.
  - PRESENT: outputs held stable. At an edge with fpu_input_ack==1: pop (rd_ptr++ with wrap), fpu_input_rdy=0, go to GAP.
  - GAP: exactly one cycle with fpu_input_rdy=0, then go to IDLE. Peak issue rate is one entry per 3 cycles.
- Simultaneous push and pop in the same edge: count unchanged, both pointers advance.
- Empty: fpu_input_rdy=0. fpu_data_* hold their last value. fpu_input_ack is ignored outside PRESENT.
- Ordering: strict FIFO, no reordering or bypass.

Optional Feature:
Macro: FPU_ISSUE_CMD_CHECK_EN.
- Defined: req_command values above FPU_CMD_MAX are rejected at write time.
  - No FIFO write happens.
  - req_ack still pulses so the core is not deadlocked.
  - cmd_err is set and stays 1 until reset.
- Undefined: every command is queued unchecked and cmd_err is tied to 0.

Decomposition:
- Package fpu_pkg:
  - command encoding typedef: FPU_CMD_ADD=4'h0, FPU_CMD_SUB=4'h1, FPU_CMD_MUL=4'h2, FPU_CMD_DIV=4'h3, FPU_CMD_MAX=4'h3.
  - issue-FSM state enum.
  - exponent/mantissa width constant functions shared with the fpu.
- One sub-module: fpu_issue_mem, a depth x (2*bitness+4) register-array storage with write port and asynchronous read port. Pointers, count and FSM stay in the top module.

Test Plan:
- Single op: reset, req A=32'h3F800000, B=32'h40000000, cmd=ADD with fpu_input_ack=0 -> req_ack pulses 1 cycle; fpu_input_rdy=1 one edge later with matching data; count=1. Then ack=1 -> rdy drops, count=0.
- Fill: depth=4, issue 5 requests with fpu_input_ack=0 -> 4 acks, count=4, 5th held. One ack on the fpu side -> 5th accepted, count=4.
- Order/wrap: push 10 requests (A=1..10) against a random-latency ack -> fpu_data_a sequence is exactly 1..10 across pointer wraparound.
- Simultaneous: count=2, push on the same edge as pop -> count stays 2 and the next presented entry is correct.
- Reset mid-op: count=3, fpu_input_rdy=1, assert reset -> all outputs 0 immediately (async). After release, count=0 and no stale entry is presented.
- With FPU_ISSUE_CMD_CHECK_EN: cmd=4'h9 -> req_ack pulses, count unchanged, cmd_err=1 and sticky. Next cmd=MUL is queued normally.

Source files
------------

// File: rtl/fpu_issue_queue_pkg.sv
// Shared fpu definitions: command encoding, issue-FSM states and IEEE field widths.
package fpu_pkg;

  typedef enum logic [3:0] {
    FPU_CMD_ADD = 4'h0,
    FPU_CMD_SUB = 4'h1,
    FPU_CMD_MUL = 4'h2,
    FPU_CMD_DIV = 4'h3
  } fpu_cmd_e;

  // Highest legal opcode; kept separate because enum members may not share a value.
  localparam logic [3:0] FPU_CMD_MAX = 4'h3;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    GAP
  } issue_state_e;

  function automatic int exp_width(input int bitness);
    case (bitness)
      16:      return 5;
      32:      return 8;
      64:      return 11;
      128:     return 15;
      default: return 19;
    endcase
  endfunction

  function automatic int man_width(input int bitness);
    return bitness - exp_width(bitness) - 1;
  endfunction

endpackage

// File: rtl/fpu_issue_queue_if.sv
// Core-request and fpu-input handshake bundle for the fpu issue queue.
interface fpu_issue_queue_if #(
  parameter int bitness = 32
);
  logic               req_rdy;
  logic               req_ack;
  logic [bitness-1:0] req_a;
  logic [bitness-1:0] req_b;
  logic [3:0]         req_command;
  logic               fpu_input_rdy;
  logic               fpu_input_ack;
  logic [bitness-1:0] fpu_data_a;
  logic [bitness-1:0] fpu_data_b;
  logic [3:0]         fpu_command;

  // master: the surrounding core and fpu; slave: the issue queue itself.
  modport master (
    output req_rdy, req_a, req_b, req_command, fpu_input_ack,
    input  req_ack, fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_command
  );

  modport slave (
    input  req_rdy, req_a, req_b, req_command, fpu_input_ack,
    output req_ack, fpu_input_rdy, fpu_data_a, fpu_data_b, fpu_command
  );
endinterface

// File: rtl/fpu_issue_queue_mem.sv
// Entry storage for the fpu issue queue: synchronous write port, asynchronous read port.
module fpu_issue_mem #(
  parameter int width = 68,
  parameter int depth = 4
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] waddr,
  input  logic [width-1:0]         wdata,
  input  logic [$clog2(depth)-1:0] raddr,
  output logic [width-1:0]         rdata
);

  logic [width-1:0] mem [depth];

  // NOTE: storage has no reset; occupancy lives in the pointers/count, so stale
  // contents are never observed and the array maps onto plain flops or LUT-RAM.
  // NOTE: sequential state uses non-blocking assignment so every reader sees the pre-edge value.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fpu_issue_queue.sv
// Circular request FIFO in front of the fpu with rdy/ack handshakes on both sides.
// Optional illegal-command rejection when FPU_ISSUE_CMD_CHECK_EN is defined.
module fpu_issue_queue
  import fpu_pkg::*;
#(
  parameter int bitness = 32,
  parameter int depth   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  fpu_issue_queue_if.slave       bus,
  output logic [$clog2(depth):0] count,
  output logic                   cmd_err
);

  localparam int PTR_W   = $clog2(depth);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * bitness + 4;

  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               req_ack_q;
  logic               fpu_rdy_q;
  logic [bitness-1:0] data_a_q, data_b_q;
  logic [3:0]         cmd_q;
  logic [ENTRY_W-1:0] head;
  issue_state_e       state_q, state_d;
  logic               accept, illegal, push, load, pop;

  // The req_ack_q term stops a held request from being written a second time.
  assign accept = bus.req_rdy && !req_ack_q && (count_q < CNT_W'(depth));
  assign push   = accept && !illegal;

`ifdef FPU_ISSUE_CMD_CHECK_EN
  logic cmd_err_q;

  assign illegal = (bus.req_command > FPU_CMD_MAX);

  // Rejected commands are still acknowledged so the core never stalls on them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  cmd_err_q <= 1'b0;
    else if (accept && illegal)  cmd_err_q <= 1'b1;
  end

  assign cmd_err = cmd_err_q;
`else
  assign illegal = 1'b0;
  assign cmd_err = 1'b0;
`endif

  fpu_issue_mem #(
    .width(ENTRY_W),
    .depth(depth)
  ) u_mem (
    .clock(clock),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata({bus.req_a, bus.req_b, bus.req_command}),
    .raddr(rd_ptr_q),
    .rdata(head)
  );

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.fpu_input_ack) begin
          pop     = 1'b1;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      req_ack_q <= 1'b0;
      fpu_rdy_q <= 1'b0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_ack_q <= accept;
      fpu_rdy_q <= (state_d == PRESENT);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (load) {data_a_q, data_b_q, cmd_q} <= head;
    end
  end

  assign bus.req_ack       = req_ack_q;
  assign bus.fpu_input_rdy = fpu_rdy_q;
  assign bus.fpu_data_a    = data_a_q;
  assign bus.fpu_data_b    = data_b_q;
  assign bus.fpu_command   = cmd_q;
  assign count             = count_q;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Self-checking bench for fpu_issue_queue against a queue-based reference model.
module tb_fpu_issue_queue;
  import fpu_pkg::*;

  localparam int BITNESS = 32;
  localparam int DEPTH   = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  cmd;
  } entry_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] count;
  logic       cmd_err;

  entry_t model[$];
  int     checks   = 0;
  int     failures = 0;

  fpu_issue_queue_if #(.bitness(BITNESS)) bus();

  fpu_issue_queue #(
    .bitness(BITNESS),
    .depth  (DEPTH)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .count  (count),
    .cmd_err(cmd_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic entry_t rand_entry();
    entry_t e;
    e.a   = $urandom;
    e.b   = $urandom;
    e.cmd = 4'($urandom_range(0, 3));
    return e;
  endfunction

  task automatic push_req(input entry_t e, input bit stored);
    bit acked = 1'b0;
    bus.req_a       = e.a;
    bus.req_b       = e.b;
    bus.req_command = e.cmd;
    bus.req_rdy     = 1'b1;
    for (int i = 0; i < 20 && !acked; i++) begin
      tick();
      if (bus.req_ack === 1'b1) acked = 1'b1;
    end
    bus.req_rdy = 1'b0;
    checks++;
    if (acked !== 1'b1) begin
      failures++;
      $display("FAIL push_ack got=%0b want=1", acked);
    end
    if (stored) model.push_back(e);
  endtask

  task automatic pop_expect(input int hold);
    bit     seen = 1'b0;
    entry_t got, exp;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (bus.fpu_input_rdy === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL pop_wait got rdy=%b want=1 within 40 cycles", bus.fpu_input_rdy);
      return;
    end
    repeat (hold) tick();
    got = {bus.fpu_data_a, bus.fpu_data_b, bus.fpu_command};
    checks++;
    if (model.size() == 0) begin
      failures++;
      $display("FAIL pop_unexpected got=%h want=<none>", got);
      return;
    end
    exp = model.pop_front();
    if (got !== exp || bus.fpu_input_rdy !== 1'b1) begin
      failures++;
      $display("FAIL pop_data got=%h rdy=%b want=%h rdy=1", got, bus.fpu_input_rdy, exp);
    end
    bus.fpu_input_ack = 1'b1;
    tick();
    bus.fpu_input_ack = 1'b0;
    checks++;
    if (bus.fpu_input_rdy !== 1'b0) begin
      failures++;
      $display("FAIL pop_rdy_drop got=%b want=0", bus.fpu_input_rdy);
    end
  endtask

  task automatic test_reset();
    bus.req_rdy = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.req_command = '0;
    bus.fpu_input_ack = 1'b0;
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if ({bus.req_ack, bus.fpu_input_rdy, bus.fpu_data_a, bus.fpu_data_b, bus.fpu_command, count, cmd_err} !== '0) begin
      failures++;
      $display("FAIL reset_state got ack=%b rdy=%b a=%h b=%h cmd=%h count=%0d err=%b want all 0",
               bus.req_ack, bus.fpu_input_rdy, bus.fpu_data_a, bus.fpu_data_b, bus.fpu_command, count, cmd_err);
    end
    #3 reset = 1'b1;
    tick();
    checks++;
    if (count !== 3'd0 || bus.fpu_input_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got count=%0d rdy=%b want 0/0", count, bus.fpu_input_rdy);
    end
  endtask

  task automatic test_single();
    bus.req_a = 32'h3F800000; bus.req_b = 32'h40000000; bus.req_command = FPU_CMD_ADD;
    bus.req_rdy = 1'b1;
    tick();
    checks++;
    if (bus.req_ack !== 1'b1 || count !== 3'd1 || bus.fpu_input_rdy !== 1'b0) begin
      failures++;
      $display("FAIL single_accept got ack=%b count=%0d rdy=%b want 1/1/0", bus.req_ack, count, bus.fpu_input_rdy);
    end
    bus.req_rdy = 1'b0;
    tick();
    checks++;
    if (bus.req_ack !== 1'b0 || bus.fpu_input_rdy !== 1'b1 || bus.fpu_data_a !== 32'h3F800000 ||
        bus.fpu_data_b !== 32'h40000000 || bus.fpu_command !== FPU_CMD_ADD) begin
      failures++;
      $display("FAIL single_present got ack=%b rdy=%b a=%h b=%h cmd=%h want 0/1/3f800000/40000000/0",
               bus.req_ack, bus.fpu_input_rdy, bus.fpu_data_a, bus.fpu_data_b, bus.fpu_command);
    end
    tick();
    checks++;
    if (bus.fpu_input_rdy !== 1'b1 || count !== 3'd1) begin
      failures++;
      $display("FAIL single_hold got rdy=%b count=%0d want 1/1", bus.fpu_input_rdy, count);
    end
    bus.fpu_input_ack = 1'b1;
    tick();
    bus.fpu_input_ack = 1'b0;
    checks++;
    if (bus.fpu_input_rdy !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL single_pop got rdy=%b count=%0d want 0/0", bus.fpu_input_rdy, count);
    end
    tick();
    checks++;
    if (bus.fpu_input_rdy !== 1'b0 || bus.fpu_data_a !== 32'h3F800000) begin
      failures++;
      $display("FAIL single_empty got rdy=%b a=%h want 0/3f800000", bus.fpu_input_rdy, bus.fpu_data_a);
    end
  endtask

  task automatic test_fill();
    entry_t e5;
    bit     saw = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_req(rand_entry(), 1'b1);
    e5 = rand_entry();
    bus.req_a = e5.a; bus.req_b = e5.b; bus.req_command = e5.cmd;
    bus.req_rdy = 1'b1;
    repeat (4) begin
      tick();
      if (bus.req_ack === 1'b1) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0 || count !== 3'd4) begin
      failures++;
      $display("FAIL fill_full got ack_seen=%b count=%0d want 0/4", saw, count);
    end
    checks++;
    if (bus.fpu_input_rdy !== 1'b1 || {bus.fpu_data_a, bus.fpu_data_b, bus.fpu_command} !== model[0]) begin
      failures++;
      $display("FAIL fill_head got rdy=%b data=%h want 1/%h", bus.fpu_input_rdy,
               {bus.fpu_data_a, bus.fpu_data_b, bus.fpu_command}, model[0]);
    end
    bus.fpu_input_ack = 1'b1;
    tick();
    bus.fpu_input_ack = 1'b0;
    void'(model.pop_front());
    checks++;
    if (count !== 3'd3 || bus.req_ack !== 1'b0) begin
      failures++;
      $display("FAIL fill_pop got count=%0d ack=%b want 3/0", count, bus.req_ack);
    end
    tick();
    bus.req_rdy = 1'b0;
    model.push_back(e5);
    checks++;
    if (count !== 3'd4 || bus.req_ack !== 1'b1) begin
      failures++;
      $display("FAIL fill_late_accept got count=%0d ack=%b want 4/1", count, bus.req_ack);
    end
    for (int i = 0; i < DEPTH; i++) pop_expect($urandom_range(0, 2));
    checks++;
    if (count !== 3'd0) begin
      failures++;
      $display("FAIL fill_drain got count=%0d want 0", count);
    end
  endtask

  task automatic test_order_wrap();
    fork
      begin
        for (int i = 1; i <= 10; i++) begin
          entry_t e;
          e = rand_entry();
          e.a = 32'(i);
          repeat ($urandom_range(0, 2)) tick();
          push_req(e, 1'b1);
        end
      end
      begin
        for (int j = 0; j < 10; j++) pop_expect($urandom_range(0, 3));
      end
    join
    tick();
    checks++;
    if (count !== 3'd0 || model.size() != 0) begin
      failures++;
      $display("FAIL order_end got count=%0d left=%0d want 0/0", count, model.size());
    end
  endtask

  task automatic test_simultaneous();
    entry_t e3;
    push_req(rand_entry(), 1'b1);
    push_req(rand_entry(), 1'b1);
    repeat (2) tick();
    checks++;
    if (count !== 3'd2 || bus.fpu_input_rdy !== 1'b1 ||
        {bus.fpu_data_a, bus.fpu_data_b, bus.fpu_command} !== model[0]) begin
      failures++;
      $display("FAIL simul_setup got count=%0d rdy=%b data=%h want 2/1/%h", count, bus.fpu_input_rdy,
               {bus.fpu_data_a, bus.fpu_data_b, bus.fpu_command}, model[0]);
    end
    e3 = rand_entry();
    bus.req_a = e3.a; bus.req_b = e3.b; bus.req_command = e3.cmd;
    bus.req_rdy = 1'b1;
    bus.fpu_input_ack = 1'b1;
    tick();
    bus.req_rdy = 1'b0;
    bus.fpu_input_ack = 1'b0;
    void'(model.pop_front());
    model.push_back(e3);
    checks++;
    if (count !== 3'd2 || bus.req_ack !== 1'b1 || bus.fpu_input_rdy !== 1'b0) begin
      failures++;
      $display("FAIL simul_edge got count=%0d ack=%b rdy=%b want 2/1/0", count, bus.req_ack, bus.fpu_input_rdy);
    end
    pop_expect(0);
    pop_expect(1);
  endtask

  task automatic test_reset_mid();
    bit stale = 1'b0;
    for (int i = 0; i < 3; i++) push_req(rand_entry(), 1'b1);
    repeat (2) tick();
    checks++;
    if (count !== 3'd3 || bus.fpu_input_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_setup got count=%0d rdy=%b want 3/1", count, bus.fpu_input_rdy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.req_ack, bus.fpu_input_rdy, bus.fpu_data_a, bus.fpu_data_b, bus.fpu_command, count, cmd_err} !== '0) begin
      failures++;
      $display("FAIL rstmid_async got ack=%b rdy=%b a=%h b=%h cmd=%h count=%0d err=%b want all 0",
               bus.req_ack, bus.fpu_input_rdy, bus.fpu_data_a, bus.fpu_data_b, bus.fpu_command, count, cmd_err);
    end
    #2 reset = 1'b1;
    model.delete();
    repeat (4) begin
      tick();
      if (count !== 3'd0 || bus.fpu_input_rdy !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after got stale=%b want 0 (count=%0d rdy=%b)", stale, count, bus.fpu_input_rdy);
    end
  endtask

  task automatic test_cmd_check();
    entry_t bad, good;
    bad  = rand_entry();
    bad.cmd = 4'h9;
    good = rand_entry();
    good.cmd = FPU_CMD_MUL;
`ifdef FPU_ISSUE_CMD_CHECK_EN
    checks++;
    if (cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL cmdchk_initial got err=%b want 0", cmd_err);
    end
    push_req(bad, 1'b0);
    checks++;
    if (count !== 3'd0 || cmd_err !== 1'b1) begin
      failures++;
      $display("FAIL cmdchk_reject got count=%0d err=%b want 0/1", count, cmd_err);
    end
    repeat (3) tick();
    checks++;
    if (count !== 3'd0 || cmd_err !== 1'b1 || bus.fpu_input_rdy !== 1'b0) begin
      failures++;
      $display("FAIL cmdchk_sticky got count=%0d err=%b rdy=%b want 0/1/0", count, cmd_err, bus.fpu_input_rdy);
    end
    push_req(good, 1'b1);
    checks++;
    if (count !== 3'd1) begin
      failures++;
      $display("FAIL cmdchk_next got count=%0d want 1", count);
    end
    pop_expect(0);
    checks++;
    if (cmd_err !== 1'b1) begin
      failures++;
      $display("FAIL cmdchk_hold got err=%b want 1", cmd_err);
    end
`else
    push_req(bad, 1'b1);
    checks++;
    if (count !== 3'd1 || cmd_err !== 1'b0) begin
      failures++;
      $display("FAIL cmd_unchecked got count=%0d err=%b want 1/0", count, cmd_err);
    end
    push_req(good, 1'b1);
    pop_expect(0);
    pop_expect(0);
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_order_wrap();
    test_simultaneous();
    test_reset_mid();
    test_cmd_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
